tone_synth: RTL and testbench

Parametrised multi-channel square-wave tone generator for the speaker PMOD path. It replaces the single fixed-50% clock divider with NUM_CH independent channels. Each channel has a programmable half-period, a programmable duty cycle and glitch-free note changes: a new setting takes effect only at a period boundary. An optional mixer reports how many channels are high, for a downstream PWM/DAC stage. The block sits between the switch-to-maxcount decoder and the PMOD output pins.

---
 rtl/tone_synth.sv | 108 ++++++++++
 tb/tb_tone_synth.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/tone_synth.sv
// Multi-channel square-wave tone generator with per-channel half-period, duty and
// period-boundary note changes. Optional channel-count mixer under TONE_SYNTH_MIX_EN.
module tone_synth #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 17,
  parameter int DUTY_W = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_CH*CNT_W-1:0]      MAXCOUNT,
  input  logic [NUM_CH*DUTY_W-1:0]     DUTY,
  input  logic [NUM_CH-1:0]            LOAD,
  input  logic                         MUTE,
  output logic [NUM_CH-1:0]            SCLK,
  output logic [$clog2(NUM_CH+1)-1:0]  MIX_LVL
);

  localparam int PW    = CNT_W + 1 + DUTY_W;
  localparam int LVL_W = $clog2(NUM_CH + 1);

  logic [NUM_CH-1:0] sclk_next;

  // LOAD[i] is a fire-and-forget strobe: no ready exists, every asserted cycle
  // overwrites the shadow, and the shadow is adopted at the next period boundary.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0]  p_a;
    logic [CNT_W-1:0]  p_s;
    logic [DUTY_W-1:0] d_s;
    logic              pend;
    logic [CNT_W:0]    h_a;
    logic [CNT_W:0]    cnt;
    logic [CNT_W:0]    last;
    logic [CNT_W:0]    h_new;
    logic [PW-1:0]     prod;
    logic              idle;
    logic              period_end;
    logic              commit;

    assign last       = {p_a, 1'b1};
    assign idle       = (p_a == '0);
    assign period_end = (cnt == last);
    assign commit     = pend && (period_end || idle);

    // Threshold from the shadow values; D = 2^(DUTY_W-1) lands exactly on P+1.
    assign prod  = PW'({1'b0, p_s} + (CNT_W+1)'(1)) * PW'(d_s);
    assign h_new = (CNT_W+1)'(prod >> (DUTY_W - 1));

    assign sclk_next[i] = !MUTE && !idle && (cnt < h_a);

    always_ff @(posedge CLK) begin
      if (RST) begin
        p_a  <= '0;
        p_s  <= '0;
        d_s  <= '0;
        pend <= 1'b0;
        h_a  <= '0;
        cnt  <= '0;
      end else begin
        if (commit) begin
          p_a  <= p_s;
          h_a  <= h_new;
          cnt  <= '0;
          pend <= 1'b0;
        end else if (idle || period_end) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + (CNT_W+1)'(1);
        end
        // A strobe coinciding with a commit is captured after the old shadow was used.
        if (LOAD[i]) begin
          p_s  <= MAXCOUNT[i*CNT_W +: CNT_W];
          d_s  <= DUTY[i*DUTY_W +: DUTY_W];
          pend <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      SCLK <= '0;
    end else begin
      SCLK <= sclk_next;
    end
  end

`ifdef TONE_SYNTH_MIX_EN
  logic [LVL_W-1:0] lvl_next;

  always_comb begin
    lvl_next = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      lvl_next = lvl_next + LVL_W'(SCLK[k]);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      MIX_LVL <= '0;
    end else begin
      MIX_LVL <= lvl_next;
    end
  end
`else
  assign MIX_LVL = '0;
`endif

endmodule

// File: tb/tb_tone_synth.sv
// Directed bench for tone_synth: table-driven waveform vectors plus hand-written
// sequences for note changes, commit/load overlap, idle, mute, mixer and reset.
module tb_tone_synth;
  localparam int NUM_CH = 2;
  localparam int CNT_W  = 17;
  localparam int DUTY_W = 4;
  localparam int LVL_W  = $clog2(NUM_CH + 1);

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CH*CNT_W-1:0]  maxcount;
  logic [NUM_CH*DUTY_W-1:0] duty;
  logic [NUM_CH-1:0]        load;
  logic                     mute;
  logic [NUM_CH-1:0]        sclk;
  logic [LVL_W-1:0]         mix_lvl;

  int total  = 0;
  int passed = 0;

  typedef struct {
    int p;
    int d;
    int h;
    int t;
  } vec_t;

  vec_t vecs[9];

  tone_synth #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DUTY_W(DUTY_W)) dut (
    .CLK(clk), .RST(rst), .MAXCOUNT(maxcount), .DUTY(duty), .LOAD(load),
    .MUTE(mute), .SCLK(sclk), .MIX_LVL(mix_lvl)
  );

  always #5 clk = ~clk;

  // Advance one cycle and sample 1 ns after the edge; strobes last one cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    load = '0;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    load = '0;
    mute = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic load_ch(input int ch, input int p, input int d);
    maxcount[ch*CNT_W +: CNT_W]   = CNT_W'(p);
    duty[ch*DUTY_W +: DUTY_W]     = DUTY_W'(d);
    load[ch]                      = 1'b1;
  endtask

  function automatic int pop2(input int a, input int b);
    return a + b;
  endfunction

  initial begin
    logic [0:17] exp_glitch;
    logic [0:13] exp_overlap;
    logic [0:11] exp_idle;
    int e0, e1, prev_pop, exp_mix, base;

    maxcount = '0;
    duty     = '0;
    load     = '0;
    mute     = 1'b0;
    rst      = 1'b1;

    vecs[0] = '{p: 3, d: 8,  h: 4, t: 8};
    vecs[1] = '{p: 3, d: 4,  h: 2, t: 8};
    vecs[2] = '{p: 3, d: 15, h: 7, t: 8};
    vecs[3] = '{p: 3, d: 0,  h: 0, t: 8};
    vecs[4] = '{p: 1, d: 8,  h: 2, t: 4};
    vecs[5] = '{p: 5, d: 8,  h: 6, t: 12};
    vecs[6] = '{p: 2, d: 12, h: 4, t: 6};
    vecs[7] = '{p: 1, d: 15, h: 3, t: 4};
    vecs[8] = '{p: 0, d: 8,  h: 0, t: 1};

    do_reset();
    check("reset_sclk", int'(sclk), 0);
    check("reset_mix", int'(mix_lvl), 0);

    // Waveform vectors on channel 0: first high three cycles after LOAD.
    for (int v = 0; v < 9; v++) begin
      do_reset();
      load_ch(0, vecs[v].p, vecs[v].d);
      for (int j = 1; j <= 2 + 2 * vecs[v].t; j++) begin
        tick();
        e0 = (j >= 3 && ((j - 3) % vecs[v].t) < vecs[v].h) ? 1 : 0;
        check($sformatf("vec%0d_cyc%0d", v, j), int'(sclk), e0);
      end
    end

    // Glitch-free change at cnt=2, second LOAD replaces the first, then P=0 goes idle.
    exp_glitch = 18'b00_1111_0000_11_00_11_00;
    do_reset();
    load_ch(0, 3, 8);
    for (int j = 1; j <= 18; j++) begin
      tick();
      check($sformatf("glitch_cyc%0d", j), int'(sclk[0]), int'(exp_glitch[j-1]));
      if (j == 4) load_ch(0, 9, 8);
      if (j == 5) load_ch(0, 1, 8);
    end
    load_ch(0, 0, 8);
    exp_idle = 12'b11_0000000000;
    for (int j = 1; j <= 12; j++) begin
      tick();
      check($sformatf("idle_cyc%0d", j), int'(sclk[0]), int'(exp_idle[j-1]));
    end

    // LOAD on the commit cycle of an idle channel: P=1 runs one period, then P=3.
    exp_overlap = 14'b00_11_00_1111_0000;
    do_reset();
    load_ch(0, 1, 8);
    for (int j = 1; j <= 14; j++) begin
      tick();
      check($sformatf("overlap_cyc%0d", j), int'(sclk[0]), int'(exp_overlap[j-1]));
      if (j == 1) load_ch(0, 3, 8);
    end

    // Mute for ten cycles: output forced low, phase unaffected.
    do_reset();
    load_ch(0, 3, 8);
    for (int j = 1; j <= 30; j++) begin
      tick();
      base = (j >= 3 && ((j - 3) % 8) < 4) ? 1 : 0;
      e0   = (j >= 7 && j <= 16) ? 0 : base;
      check($sformatf("mute_cyc%0d", j), int'(sclk[0]), e0);
      mute = (j >= 6 && j <= 15);
    end
    mute = 1'b0;

    // Mixer: two channels with different periods.
    do_reset();
    load_ch(0, 3, 8);
    load_ch(1, 1, 8);
    prev_pop = 0;
    for (int j = 1; j <= 24; j++) begin
      tick();
      e0 = (j >= 3 && ((j - 3) % 8) < 4) ? 1 : 0;
      e1 = (j >= 3 && ((j - 3) % 4) < 2) ? 1 : 0;
`ifdef TONE_SYNTH_MIX_EN
      exp_mix = prev_pop;
`else
      exp_mix = 0;
`endif
      check($sformatf("mix_sclk_cyc%0d", j), int'(sclk), e1 * 2 + e0);
      check($sformatf("mix_lvl_cyc%0d", j), int'(mix_lvl), exp_mix);
      prev_pop = pop2(e0, e1);
    end

    // Reset while both channels are active and pending; RST beats a coincident LOAD.
    load_ch(0, 5, 8);
    load_ch(1, 5, 8);
    tick();
    rst = 1'b1;
    load_ch(0, 6, 8);
    load_ch(1, 6, 8);
    tick();
    rst = 1'b0;
    check("midrst_sclk", int'(sclk), 0);
    check("midrst_mix", int'(mix_lvl), 0);
    for (int j = 1; j <= 20; j++) begin
      tick();
      check($sformatf("postrst_sclk_cyc%0d", j), int'(sclk), 0);
      check($sformatf("postrst_mix_cyc%0d", j), int'(mix_lvl), 0);
    end
    load_ch(0, 1, 8);
    for (int j = 1; j <= 8; j++) begin
      tick();
      e0 = (j >= 3 && ((j - 3) % 4) < 2) ? 1 : 0;
      check($sformatf("reload_cyc%0d", j), int'(sclk), e0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
